// File: rtl/btn_if.sv
// btn_if: raw button inputs and conditioned level/press/release outputs for btn_cond.
interface btn_if;
    logic [4:0] btn_in;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    modport master(output btn_in, input btn_level, input btn_press, input btn_release);
    modport slave(input btn_in, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/btn_cond.sv
// btn_cond: five-button synchronizer, debouncer and press/release/auto-repeat pulse generator.
module btn_cond #(
    parameter int unsigned DB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY = 40000000,
    parameter int unsigned REPEAT_RATE  = 10000000,
    parameter logic [4:0]  REPEAT_MASK  = 5'b11110
) (
    input logic  clk,
    input logic  rst,
    btn_if.slave bus
);
    localparam logic [19:0] DB_MAX   = 20'(DB_CYCLES - 1);
    localparam logic [25:0] DLY_MAX  = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RATE_MAX = 26'(REPEAT_RATE - 1);
    typedef enum logic [1:0] {REL, DELAY, REPEAT} rep_state_e;
    logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d, level_q, level_d;
    logic [4:0] press_q, press_d, release_q, release_d;
    logic [4:0] diff, toggle, rise, fall, rep_hit;
    logic [19:0] db_cnt_q [5];
    logic [19:0] db_cnt_d [5];
    logic [25:0] rep_cnt_q [5];
    logic [25:0] rep_cnt_d [5];
    rep_state_e state_q [5];
    rep_state_e state_d [5];
    always_comb begin
        sync1_d = bus.btn_in;
        sync2_d = sync1_q;
        for (int i = 0; i < 5; i++) begin
            diff[i]      = sync2_q[i] ^ level_q[i];
            toggle[i]    = diff[i] && db_cnt_q[i] == DB_MAX;
            db_cnt_d[i]  = (diff[i] && !toggle[i]) ? db_cnt_q[i] + 20'd1 : 20'd0;
            level_d[i]   = level_q[i] ^ toggle[i];
            rise[i]      = toggle[i] & ~level_q[i];
            fall[i]      = toggle[i] & level_q[i];
            rep_hit[i]   = (state_q[i] == DELAY && rep_cnt_q[i] == DLY_MAX) ||
                           (state_q[i] == REPEAT && rep_cnt_q[i] == RATE_MAX);
            state_d[i]   = state_q[i];
            rep_cnt_d[i] = rep_cnt_q[i];
            if (fall[i]) begin
                state_d[i]   = REL;
                rep_cnt_d[i] = 26'd0;
            end else if (rise[i] && REPEAT_MASK[i]) begin
                state_d[i]   = DELAY;
                rep_cnt_d[i] = 26'd0;
            end else if (state_q[i] != REL) begin
                state_d[i]   = rep_hit[i] ? REPEAT : state_q[i];
                rep_cnt_d[i] = rep_hit[i] ? 26'd0 : rep_cnt_q[i] + 26'd1;
            end
            // a release edge wins over a coincident repeat so press and release never overlap
            press_d[i]   = rise[i] | (rep_hit[i] & ~fall[i]);
            release_d[i] = fall[i];
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i]  <= '0;
                rep_cnt_q[i] <= '0;
                state_q[i]   <= REL;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rep_cnt_q[i] <= rep_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end
    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
endmodule

// File: tb/tb_btn_cond.sv
// tb_btn_cond: table plus scoreboard bench for btn_cond at DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_btn_cond;
    logic clk = 1'b0;
    logic rst = 1'b0;
    btn_if bus();
    btn_cond #(.DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { int e; logic [4:0] p; logic [4:0] r; } ev_t;
    typedef struct { logic [4:0] btn; int hold; int p_off; int r_off; logic [4:0] lvl; } vec_t;
    ev_t sb[$];
    int e = 0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %b, expected %b", name, e, got, exp);
        end
    endtask

    task automatic mon();
        ev_t ev;
        if (sb.size() > 0 && sb[0].e <= e) begin
            ev = sb.pop_front();
            tests++;
            if (ev.e != e || bus.btn_press !== ev.p || bus.btn_release !== ev.r) begin
                fails++;
                $display("FAIL pulse @edge %0d: press=%b release=%b, expected press=%b release=%b at edge %0d",
                         e, bus.btn_press, bus.btn_release, ev.p, ev.r, ev.e);
            end
        end else if (bus.btn_press !== 5'b0 || bus.btn_release !== 5'b0) begin
            tests++;
            fails++;
            $display("FAIL spurious pulse @edge %0d: press=%b release=%b, expected none",
                     e, bus.btn_press, bus.btn_release);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            mon();
        end
    endtask

    task automatic push(input int at, input logic [4:0] p, input logic [4:0] r);
        sb.push_back('{at, p, r});
    endtask

    initial begin
        vec_t vt[5];
        logic pat[7];
        int s, a, r0;
        vt[0] = '{5'b00010, 8, 5, 13, 5'b00010};
        vt[1] = '{5'b00001, 3, -1, -1, 5'b00000};
        vt[2] = '{5'b00100, 2, -1, -1, 5'b00000};
        vt[3] = '{5'b00001, 4, 5, 9, 5'b00000};
        vt[4] = '{5'b00001, 35, 5, 40, 5'b00001};
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bus.btn_in = 5'b11111;
        step(3);
        chk("reset level", bus.btn_level, 5'b0);
        chk("reset press", bus.btn_press, 5'b0);
        chk("reset release", bus.btn_release, 5'b0);
        bus.btn_in = 5'b0;
        rst = 1'b1;
        step(10);
        chk("idle level", bus.btn_level, 5'b0);
        for (int i = 0; i < 5; i++) begin
            s = e + 1;
            if (vt[i].p_off >= 0) push(s + vt[i].p_off, vt[i].btn, 5'b0);
            if (vt[i].r_off >= 0) push(s + vt[i].r_off, 5'b0, vt[i].btn);
            bus.btn_in = vt[i].btn;
            step(vt[i].hold);
            chk($sformatf("vec%0d held level", i), bus.btn_level, vt[i].lvl);
            bus.btn_in = 5'b0;
            step(20);
            chk($sformatf("vec%0d idle level", i), bus.btn_level, 5'b0);
        end
        // bounce on right: final 0->1 is sampled at s+6, acceptance five edges later
        s = e + 1;
        push(s + 11, 5'b00100, 5'b0);
        push(s + 17, 5'b0, 5'b00100);
        for (int k = 0; k < 7; k++) begin
            bus.btn_in = {2'b0, pat[k], 2'b0};
            step(1);
        end
        step(4);
        chk("bounce early level", bus.btn_level, 5'b0);
        step(1);
        chk("bounce accepted level", bus.btn_level, 5'b00100);
        bus.btn_in = 5'b0;
        step(20);
        // up auto-repeat; the fall lands on a would-be repeat edge, which must stay silent
        s = e + 1;
        a = s + 5;
        push(a, 5'b01000, 5'b0);
        for (int t = 10; t <= 34; t += 3) push(a + t, 5'b01000, 5'b0);
        push(a + 37, 5'b0, 5'b01000);
        bus.btn_in = 5'b01000;
        step(37);
        chk("up held level", bus.btn_level, 5'b01000);
        bus.btn_in = 5'b0;
        step(20);
        // left and down together stay aligned through repeats
        s = e + 1;
        push(s + 5, 5'b10010, 5'b0);
        for (int t = 15; t <= 24; t += 3) push(s + t, 5'b10010, 5'b0);
        push(s + 25, 5'b0, 5'b10010);
        bus.btn_in = 5'b10010;
        step(20);
        chk("dual held level", bus.btn_level, 5'b10010);
        bus.btn_in = 5'b0;
        step(20);
        // reset while up is in REPEAT, then re-debounce with the button still held
        s = e + 1;
        push(s + 5, 5'b01000, 5'b0);
        push(s + 15, 5'b01000, 5'b0);
        bus.btn_in = 5'b01000;
        step(17);
        rst = 1'b0;
        #1;
        chk("mid reset level", bus.btn_level, 5'b0);
        chk("mid reset press", bus.btn_press, 5'b0);
        chk("mid reset release", bus.btn_release, 5'b0);
        step(3);
        chk("held reset level", bus.btn_level, 5'b0);
        rst = 1'b1;
        r0 = e;
        push(r0 + 6, 5'b01000, 5'b0);
        push(r0 + 16, 5'b01000, 5'b0);
        push(r0 + 19, 5'b01000, 5'b0);
        push(r0 + 22, 5'b01000, 5'b0);
        push(r0 + 25, 5'b0, 5'b01000);
        step(5);
        chk("post reset early level", bus.btn_level, 5'b0);
        step(1);
        chk("post reset level", bus.btn_level, 5'b01000);
        step(13);
        bus.btn_in = 5'b0;
        step(20);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d pulses never seen, expected 0 (next at edge %0d)", sb.size(), sb[0].e);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range 1..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 40000000: cycles from the press pulse to the first auto-repeat pulse; legal range 1..2^26-1.
REQ-003 Parameter REPEAT_RATE, default 10000000: cycles between subsequent auto-repeat pulses; legal range 1..2^26-1.
REQ-004 Parameter REPEAT_MASK, default 5'b11110: per-button auto-repeat enable; centre does not repeat by default.
REQ-005 clk  input  1  system clock; all state is clocked on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 btn_in  input  5  raw, asynchronous push-button inputs; bit 0 centre, 1 left, 2 right, 3 up, 4 down.
REQ-008 btn_level  output  5  debounced button level; same bit order as btn_in.
REQ-009 btn_press  output  5  one-cycle pulse on an accepted press and on each auto-repeat.
REQ-010 btn_release  output  5  one-cycle pulse on an accepted release.

Function
REQ-011 Each btn_in bit SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Each bit SHALL have an independent debounce counter, 20 bits wide, that increments on every edge where the synchronized value differs from btn_level.
REQ-013 The counter SHALL clear to 0 on any edge where the synchronized value equals btn_level, so any bounce restarts the count.
REQ-014 On the edge where the counter would reach DB_CYCLES, btn_level SHALL toggle and the counter SHALL clear.
REQ-015 Latency: with the raw input held stable, btn_level SHALL change on edge DB_CYCLES+2, where edge 1 is the first edge that samples the new raw value.
REQ-016 btn_press[i] SHALL be registered high for exactly the one cycle following the edge on which btn_level[i] rises.
REQ-017 btn_release[i] SHALL be registered high for exactly the one cycle following the edge on which btn_level[i] falls.
REQ-018 Each bit SHALL have an auto-repeat state machine with states REL, DELAY and REPEAT, and a 26-bit repeat counter.
REQ-019 REL -> DELAY when btn_level rises and REPEAT_MASK[i]=1; the counter clears on this transition.
REQ-020 DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1: btn_press pulses and the counter clears.
REQ-021 In REPEAT, btn_press SHALL pulse and the counter SHALL clear each time the counter reaches REPEAT_RATE-1.
REQ-022 DELAY or REPEAT -> REL when btn_level falls; no repeat pulse SHALL be issued on that edge or afterwards.
REQ-023 With REPEAT_MASK[i]=0, the state machine SHALL remain in REL and only the single press pulse SHALL occur.
REQ-024 Bits SHALL be fully independent: simultaneous presses produce simultaneous pulses, and one bit's activity never delays another's.
REQ-025 btn_press and btn_release for the same bit SHALL never be high in the same cycle.
REQ-026 A press and release both shorter than DB_CYCLES SHALL produce no output change.

Reset
REQ-027 While rst=0, asynchronously: synchronizers, btn_level, btn_press and btn_release SHALL be 0, all counters 0, all state machines in REL.
REQ-028 A reset asserted mid-debounce or mid-repeat SHALL abort it. After rst releases with a button held, the button SHALL be re-debounced and produce a fresh press pulse at the REQ-015 latency.
REQ-029 The first edge after rst deasserts SHALL be treated as edge 1 of synchronization; no output pulse SHALL occur in the reset-release cycle.

Verification (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 Clean press of left at edge 1, held 8 cycles, then released -> btn_level[1] rises on edge 6; btn_press[1] high for one cycle after edge 6; btn_release[1] pulses 6 edges after the release is first sampled.
REQ-031 Bounce: btn_in[2] pattern 1,1,0,1,1,0,1 followed by a steady 1 -> btn_level[2] rises only 6 edges after the final 0->1 transition; exactly one press pulse.
REQ-032 Hold up for 30 cycles after acceptance -> press pulses at acceptance edge A, then A+10, A+13, A+16 ... until release; no pulse after btn_level falls.
REQ-033 Hold centre for 30 cycles with the default mask -> exactly one btn_press[0] pulse.
REQ-034 Press left and down on the same edge -> btn_press[1] and btn_press[4] are asserted in the same cycle, and their repeat pulses stay aligned.
REQ-035 Assert rst during REPEAT with up held, then release rst -> all outputs are 0 during reset; a new press pulse follows 6 edges after release; the repeat timing restarts from REPEAT_DELAY.
